// File: rtl/weight_loader_pkg.sv
// Shared configuration for the weight fill path: array geometry, weight width,
// buffer depth and the loader state encoding.
package weight_loader_pkg;

  localparam int unsigned sys_cols       = 4;
  localparam int unsigned W_BITWIDTH     = 16;
  localparam int unsigned super_w_rows   = 4;
  localparam int unsigned w_buffer_depth = 16;

  typedef enum logic [1:0] {WL_IDLE, WL_LOAD, WL_DONE} wl_state_t;

  // Index width for a counter spanning 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_loader.sv
// Fills the per-column weight FIFOs with one tile in column-major order from a
// single valid/ready stream, and pulses done when the tile is complete.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int unsigned COLS  = sys_cols,
  parameter int unsigned DW    = W_BITWIDTH,
  parameter int unsigned ROWS  = super_w_rows,
  parameter int unsigned DEPTH = w_buffer_depth
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_data,
  input  logic [COLS-1:0] col_full,
  output logic [COLS-1:0] o_wr_en,
  output logic [DW-1:0]   o_wr_data,
  output logic            busy,
  output logic            done,
  output logic [31:0]     stall_cnt
);

  localparam int unsigned RW = cnt_width(ROWS);
  localparam int unsigned CW = cnt_width(COLS);

  if (ROWS > DEPTH || COLS < 1) begin : g_bad_cfg
    $fatal(1, "weight_loader: ROWS must not exceed DEPTH and COLS must be at least 1");
  end

  wl_state_t      r_state;
  wl_state_t      w_state_nxt;
  logic [RW-1:0]  r_row_cnt;
  logic [CW-1:0]  r_col_idx;
  logic           w_col_full;
  logic           w_accept;
  logic           w_last;

  // Full flag of the column currently being filled.
  always_comb begin
    w_col_full = 1'b0;
    for (int unsigned i = 0; i < COLS; i++) begin
      if (r_col_idx == CW'(i)) begin
        w_col_full = col_full[i];
      end
    end
  end

  assign s_ready   = (r_state == WL_LOAD) && !w_col_full;
  assign w_accept  = s_valid && s_ready;
  assign w_last    = (r_col_idx == CW'(COLS - 1)) && (r_row_cnt == RW'(ROWS - 1));
  assign o_wr_data = s_data;
  assign busy      = (r_state != WL_IDLE);
  assign done      = (r_state == WL_DONE);

  always_comb begin
    o_wr_en = '0;
    for (int unsigned i = 0; i < COLS; i++) begin
      o_wr_en[i] = w_accept && (r_col_idx == CW'(i));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WL_IDLE: if (start) w_state_nxt = WL_LOAD;
      WL_LOAD: if (w_accept && w_last) w_state_nxt = WL_DONE;
      WL_DONE: w_state_nxt = WL_IDLE;
      default: w_state_nxt = WL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= WL_IDLE;
      r_row_cnt <= '0;
      r_col_idx <= '0;
      stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == WL_IDLE && start) begin
        r_row_cnt <= '0;
        r_col_idx <= '0;
      end else if (w_accept) begin
        // The final accept leaves the column index parked; the tile exits LOAD.
        if (r_row_cnt == RW'(ROWS - 1)) begin
          r_row_cnt <= '0;
          if (!w_last) begin
            r_col_idx <= r_col_idx + CW'(1);
          end
        end else begin
          r_row_cnt <= r_row_cnt + RW'(1);
        end
      end
      if (r_state == WL_LOAD && s_valid && !s_ready && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader with a 4-column, 3-row tile: per-cycle
// vector table plus hand-written multi-cycle tile sequences.
module tb_weight_loader;

  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int DW   = 16;
  localparam int TILE = COLS * ROWS;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            s_valid;
  logic            s_ready;
  logic [DW-1:0]   s_data;
  logic [COLS-1:0] col_full;
  logic [COLS-1:0] o_wr_en;
  logic [DW-1:0]   o_wr_data;
  logic            busy;
  logic            done;
  logic [31:0]     stall_cnt;

  weight_loader #(.COLS(COLS), .DW(DW), .ROWS(ROWS), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .col_full(col_full), .o_wr_en(o_wr_en), .o_wr_data(o_wr_data),
    .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int wq[$];
  int t_start, t_first, t_last;

  always @(posedge clk) cyc <= cyc + 1;

  // Model of the column FIFOs: record every write as column*65536 + data.
  always @(negedge clk) begin
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    for (int i = 0; i < COLS; i++) begin
      if (o_wr_en[i]) wq.push_back(i * 65536 + int'(o_wr_data));
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic            rst;
    logic            start;
    logic            sv;
    logic [DW-1:0]   d;
    logic [COLS-1:0] full;
    logic            e_rdy;
    logic [COLS-1:0] e_wr;
    logic            e_busy;
    logic            e_done;
    logic [31:0]     e_stall;
  } vec_t;

  function automatic vec_t mkv(input logic r, input logic st, input logic sv, input int d,
                               input logic [COLS-1:0] full, input logic e_rdy,
                               input logic [COLS-1:0] e_wr, input logic e_busy,
                               input logic e_done, input int e_stall);
    vec_t v;
    v.rst = r; v.start = st; v.sv = sv; v.d = DW'(d); v.full = full;
    v.e_rdy = e_rdy; v.e_wr = e_wr; v.e_busy = e_busy; v.e_done = e_done;
    v.e_stall = 32'(e_stall);
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; col_full = '0;
    tick();
    tick();
    rst = 1'b0;
    wq.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  // Stream weights 1..TILE starting with a start pulse in the current cycle.
  task automatic run_tile(input bit bubbles, input int stall_w, input int stall_len,
                          input int ign_start_w, input int rst_after);
    int k = 0;
    int left = stall_len;
    int guard = 0;
    bit ph = 1'b1;
    start = 1'b1; s_valid = 1'b0; col_full = '0; t_start = cyc;
    tick();
    start = 1'b0;
    while (k < TILE && guard < 200) begin
      if (rst_after > 0 && k == rst_after) break;
      s_valid  = bubbles ? ph : 1'b1;
      ph       = ~ph;
      s_data   = DW'(k + 1);
      col_full = '0;
      start    = (ign_start_w == k + 1);
      if (stall_w == k + 1 && left > 0) begin
        col_full[(stall_w - 1) / ROWS] = 1'b1;
        left--;
      end
      #1;
      if (col_full != '0) begin
        chk("stall_ready", 64'(s_ready), 64'd0);
        chk("stall_wren", 64'(o_wr_en), 64'd0);
      end
      if (s_valid && s_ready) begin
        if (k == 0) t_first = cyc;
        t_last = cyc;
        k++;
      end
      guard++;
      tick();
    end
    s_valid = 1'b0; start = 1'b0; col_full = '0;
    if (guard >= 200) chk("tile_timeout", 64'(k), 64'(TILE));
  endtask

  task automatic finish_tile(input int done_off);
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_busy", 64'(busy), 64'd1);
    tick();
    chk("post_done", 64'(done), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_ready", 64'(s_ready), 64'd0);
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("done_cycle", 64'(done_cyc), 64'(t_start + done_off));
    chk("fifo_count", 64'(wq.size()), 64'(TILE));
    for (int i = 0; i < TILE && i < wq.size(); i++) begin
      chk("fifo_data", 64'(wq[i]), 64'((i / ROWS) * 65536 + i + 1));
    end
    wq.delete();
    done_cnt = 0;
  endtask

  vec_t tbl[12];
  int   t_last1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst start sv data full | rdy wr busy done stall
    tbl[0]  = mkv(0, 0, 1, 'hAA, 4'b0000, 0, 4'b0000, 0, 0, 0);
    tbl[1]  = mkv(0, 1, 1, 'hAA, 4'b0000, 0, 4'b0000, 0, 0, 0);
    tbl[2]  = mkv(0, 0, 1, 1,    4'b0000, 1, 4'b0001, 1, 0, 0);
    tbl[3]  = mkv(0, 0, 1, 2,    4'b0001, 0, 4'b0000, 1, 0, 0);
    tbl[4]  = mkv(0, 0, 0, 2,    4'b0001, 0, 4'b0000, 1, 0, 1);
    tbl[5]  = mkv(0, 0, 1, 2,    4'b0010, 1, 4'b0001, 1, 0, 1);
    tbl[6]  = mkv(0, 1, 1, 3,    4'b0000, 1, 4'b0001, 1, 0, 1);
    tbl[7]  = mkv(0, 0, 1, 4,    4'b0001, 1, 4'b0010, 1, 0, 1);
    tbl[8]  = mkv(0, 0, 1, 5,    4'b0010, 0, 4'b0000, 1, 0, 1);
    tbl[9]  = mkv(1, 0, 0, 6,    4'b0000, 1, 4'b0000, 1, 0, 2);
    tbl[10] = mkv(1, 1, 0, 7,    4'b0000, 0, 4'b0000, 0, 0, 0);
    tbl[11] = mkv(0, 0, 1, 9,    4'b0000, 0, 4'b0000, 0, 0, 0);

    do_reset();
    chk("rst_ready", 64'(s_ready), 64'd0);
    chk("rst_wren", 64'(o_wr_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);

    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; s_valid = tbl[i].sv;
      s_data = tbl[i].d; col_full = tbl[i].full;
      #1;
      chk($sformatf("vec%0d_ready", i), 64'(s_ready), 64'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_wren", i), 64'(o_wr_en), 64'(tbl[i].e_wr));
      chk($sformatf("vec%0d_wdata", i), 64'(o_wr_data), 64'(tbl[i].d));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
      chk($sformatf("vec%0d_done", i), 64'(done), 64'(tbl[i].e_done));
      chk($sformatf("vec%0d_stall", i), 64'(stall_cnt), 64'(tbl[i].e_stall));
      tick();
    end

    // Basic tile
    do_reset();
    run_tile(1'b0, 0, 0, 0, 0);
    finish_tile(13);
    chk("basic_stall", 64'(stall_cnt), 64'd0);

    // Full stall on column 1 while weight 4 is presented
    do_reset();
    run_tile(1'b0, 4, 5, 0, 0);
    finish_tile(18);
    chk("full_stall_cnt", 64'(stall_cnt), 64'd5);

    // Bubbles on s_valid
    do_reset();
    run_tile(1'b1, 0, 0, 0, 0);
    chk("bubble_last", 64'(t_last), 64'(t_start + 23));
    finish_tile(24);

    // Ignored inputs: s_valid in IDLE, start mid-LOAD
    do_reset();
    s_valid = 1'b1; s_data = DW'(16'h55);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("idle_ready", 64'(s_ready), 64'd0);
      tick();
    end
    s_valid = 1'b0;
    chk("idle_nowrite", 64'(wq.size()), 64'd0);
    run_tile(1'b0, 0, 0, 6, 0);
    finish_tile(13);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_second_tile", 64'(busy), 64'd0);
    end
    chk("ign_done_cnt", 64'(done_cnt), 64'd0);

    // Reset after 7 accepts, then a fresh tile
    do_reset();
    run_tile(1'b0, 0, 0, 0, 7);
    chk("partial_writes", 64'(wq.size()), 64'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_ready", 64'(s_ready), 64'd0);
    chk("mid_rst_wren", 64'(o_wr_en), 64'd0);
    tick();
    chk("mid_rst_nodone", 64'(done_cnt), 64'd0);
    wq.delete();
    run_tile(1'b0, 0, 0, 0, 0);
    finish_tile(13);

    // Back-to-back tiles
    do_reset();
    run_tile(1'b0, 0, 0, 0, 0);
    finish_tile(13);
    t_last1 = t_last;
    run_tile(1'b0, 0, 0, 0, 0);
    chk("b2b_gap", 64'(t_first - t_last1), 64'd3);
    finish_tile(13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
# weight_loader

Upstream fill stage for the weight buffers. It accepts a single valid/ready stream of weights and writes one tile into the per-column weight FIFOs in column-major order: `super_w_rows` weights into column 0, then column 1, and so on through column `sys_cols-1`. It drives the FIFO write side (`wr_en`/`din`), which the read side of the weight buffers leaves to an external writer. It signals tile completion so the controller can start the skewed read into the systolic array.

## Interface
- `COLS`, default `sys_cols`: number of column FIFOs.
- `DW`, default `W_BITWIDTH`: weight width.
- `ROWS`, default `super_w_rows`: weights per column per tile.
- `DEPTH`, default `w_buffer_depth`: FIFO depth, used only for the elaboration check.

- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request to load one tile; sampled only in IDLE.
- `s_valid`, in, 1: input weight valid.
- `s_ready`, out, 1: loader accepts `s_data` this cycle.
- `s_data`, in, DW: input weight.
- `col_full`, in, COLS: per-FIFO full flags.
- `o_wr_en`, out, COLS: per-FIFO write enable, one-hot or zero.
- `o_wr_data`, out, DW: write data, broadcast to all FIFOs.
- `busy`, out, 1: high in LOAD and DONE.
- `done`, out, 1: one-cycle pulse at tile completion.
- `stall_cnt`, out, 32: cycles in LOAD with `s_valid && !s_ready`.

## Operation
- **States:** IDLE, LOAD, DONE.
  - IDLE→LOAD on `start`.
  - LOAD→DONE on the accept with `col_idx==COLS-1 && row_cnt==ROWS-1`.
  - DONE→IDLE unconditionally.
- **Counters:**
  - `row_cnt` is 0..ROWS-1 and `col_idx` is 0..COLS-1.
  - Both clear on entry to LOAD.
  - On accept, `row_cnt` increments. At ROWS-1 it wraps to 0 and `col_idx` increments.
  - `col_idx` does not wrap; the last accept exits LOAD.
- **Handshake:**
  - `s_ready = (state==LOAD) && !col_full[col_idx]`, combinational.
  - Accept when `s_valid && s_ready`.
  - `s_ready` must not depend on `s_valid`.
- **Write path:** combinational and zero-latency.
  - `o_wr_en[col_idx] = accept`; all other bits are 0.
  - `o_wr_data = s_data`.
- **Ignored and blocked inputs:**
  - `start` in LOAD or DONE is ignored and not queued.
  - `s_valid` outside LOAD is not accepted: `s_ready` is 0 and no write occurs.
  - A full FIFO stalls the whole stream. No skip to the next column.
- **`stall_cnt`:** increments by 1 in each LOAD cycle where `s_valid && !s_ready`. It saturates at 2^32-1 and clears only on `rst`.
- **Elaboration check:** fatal error if `ROWS > DEPTH` or `COLS < 1`.

## Timing
- **Reset values:** state IDLE, counters 0, `busy` 0, `done` 0, `stall_cnt` 0. Therefore `s_ready` 0 and `o_wr_en` 0.
- **Start:** `start` high at edge t. LOAD is active from cycle t+1, so `s_ready` can first be 1 in cycle t+1.
- **Minimum tile time:** COLS×ROWS LOAD cycles with `s_valid` held high and no FIFO full.
- **Done:** last accept in cycle n gives DONE in cycle n+1, with `done`=1 and `busy`=1. Cycle n+2 is IDLE.
- **Back-to-back tiles:** the earliest next `start` is sampled in cycle n+2, which puts LOAD at n+3.
- **Column boundary:** the accept at `row_cnt==ROWS-1` writes the old column. The next cycle targets the new column, and `s_ready` then reflects `col_full` of the new column.
- **`col_full`:** must be valid in the same cycle it is used. A write into the last free slot is allowed. Full rising next cycle deasserts `s_ready` then.
- **Reset mid-LOAD:** return to IDLE next cycle with no `done`. The partially written tile is discarded by the same `rst` clearing the FIFOs.
- **Simultaneous `rst` and `start`:** `rst` wins.

## Structure
- **Config package:** `sys_cols`, `W_BITWIDTH`, `super_w_rows`, `w_buffer_depth` already live there. Add `typedef enum logic [1:0] {WL_IDLE, WL_LOAD, WL_DONE} wl_state_t`.
- **Counter widths:** `$clog2` of ROWS and COLS, minimum 1 bit.
- **No sub-module:** a single always_ff for state, counters and `stall_cnt`, plus combinational ready/write logic.
- **Top-level wiring:** `o_wr_en[i]` and `o_wr_data` connect to `wr_en`/`din` of column FIFO i, and its `full` connects to `col_full[i]`.

## Test plan
All scenarios use bench overrides COLS=4, ROWS=3.
- **Basic tile:** reset, `start`, stream weights 1..12 with `s_valid` held high. Expect FIFO0 gets 1,2,3, FIFO1 4,5,6, FIFO2 7,8,9, FIFO3 10,11,12. `done` pulses exactly once, 13 cycles after `start`, and `stall_cnt`=0.
- **Full stall:** force `col_full[1]`=1 for 5 cycles when weight 4 is presented. Expect `s_ready`=0 for those 5 cycles, no write, weight 4 later lands in FIFO1, and `stall_cnt`=5.
- **Bubbles:** `s_valid` toggles 1,0,1,0. Expect writes only on accepted cycles, correct column order, and `done` after the 12th accept.
- **Ignored inputs:** `s_valid` high in IDLE and `start` pulsed mid-LOAD. Expect no writes in IDLE, exactly one `done`, and no second tile started.
- **Reset mid-LOAD:** assert `rst` after 7 accepts. Expect IDLE next cycle, all outputs at reset values, and no `done`. A fresh `start` then loads 12 weights correctly.
- **Back-to-back tiles:** `start` asserted in the first IDLE cycle after DONE. Expect the second tile's first accept 3 cycles after the first tile's last accept.
